vic_bus_master: RTL
===================

VIC_BUS_MASTER -- requirements
Module: vic_bus_master

Interface
REQ-001 SHALL have port clk_dot4x  input  1  4x dot clock; sole clock, all logic on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port clk_phi  input  1  CPU phi clock (clk_dot4x/32), sampled synchronously.
REQ-004 SHALL have port aec  input  1  high = CPU owns bus.
REQ-005 SHALL have port ba  input  1  low = VIC requests bus; CPU reads stall.
REQ-006 SHALL have port cmd_valid  input  1  host request strobe.
REQ-007 SHALL have port cmd_we  input  1  1 = register write, 0 = read.
REQ-008 SHALL have port cmd_addr  input  6  VIC register address.
REQ-009 SHALL have port cmd_wdata  input  8  write data.
REQ-010 SHALL have port cmd_ready  output  1  high only in IDLE.
REQ-011 SHALL have port ce  output  1  chip enable to VIC, active low.
REQ-012 SHALL have port rw  output  1  high = read, low = write.
REQ-013 SHALL have port ado  output  6  address to VIC adi.
REQ-014 SHALL have port dbo  output  8  write data to VIC dbi.
REQ-015 SHALL have port db_oe  output  1  enables the dbo bus drivers.
REQ-016 SHALL have port dbi  input  8  read data from VIC dbo.
REQ-017 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-018 SHALL have port rsp_rdata  output  8  read result, held until the next completion.
REQ-019 SHALL have port rsp_err  output  1  timeout flag, qualified by rsp_valid.

Function
REQ-020 SHALL register clk_phi into phi_d; phi_rise = clk_phi & ~phi_d.
REQ-021 SHALL keep a 5-bit phase counter: 0 on the phi_rise cycle, +1 per clock, saturating at 31.
REQ-022 SHALL implement states IDLE, WAIT, ACCESS, DONE.
REQ-023 IDLE: on cmd_valid & cmd_ready, SHALL latch we/addr/wdata and go to WAIT; cmd_valid without ready is ignored.
REQ-024 WAIT -> ACCESS SHALL occur on phi_rise with aec=1, and ba=1 for reads (writes ignore ba).
REQ-025 ACCESS phases 1-15: ce=0, rw=~we, ado=latched addr.
REQ-026 For writes in ACCESS phases 2-15: db_oe=1, dbo=wdata.
REQ-027 For reads: SHALL capture dbi into rsp_rdata at phase 14.
REQ-028 At phase 16 (phi fall): ce=1, rw=1, db_oe=0; go to DONE.
REQ-029 DONE: rsp_valid=1 for exactly one cycle, then IDLE.
REQ-030 Sustained throughput: at most one access per phi cycle.
REQ-031 Writes SHALL leave rsp_rdata unchanged; rsp_err=0 on normal completion.
REQ-032 If aec drops during ACCESS, the access SHALL still complete unchanged; aec is checked only at phi_rise.

Reset
REQ-033 While rst is high: state=IDLE, ce=1, rw=1, db_oe=0, ado=0, dbo=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, phase=31, phi_d=0, cmd_ready=0.
REQ-034 Reset asserted mid-ACCESS SHALL release ce/db_oe immediately (asynchronously) and abandon the access without an rsp_valid.
REQ-035 cmd_ready SHALL rise on the first clock after rst deasserts.

Configuration
REQ-036 Macro BUS_MASTER_TIMEOUT_EN defined: an 8-bit counter SHALL count phi_rise events in WAIT where the start condition fails; at 255 the block SHALL go to DONE with rsp_err=1 and no bus access.
REQ-037 BUS_MASTER_TIMEOUT_EN undefined: WAIT SHALL persist indefinitely, and rsp_err SHALL be constant 0.

Verification
REQ-038 Write 0x20 <- 0x0E with aec=ba=1 -> ce low for phases 1-15, db_oe phases 2-15 with dbo=0x0E, rsp_valid at phase 16+1.
REQ-039 Read 0x12 with dbi=0x37 -> rsp_rdata=0x37, rsp_err=0, rw high throughout.
REQ-040 Read issued while ba=0 for 3 phi cycles -> no ce assertion until the first phi_rise with ba=1.
REQ-041 Write issued with ba=0, aec=1 -> access starts on the next phi_rise.
REQ-042 rst pulsed at ACCESS phase 8 -> ce=1 and db_oe=0 within the same cycle, no rsp_valid, cmd_ready=1 one clock after release.
REQ-043 With BUS_MASTER_TIMEOUT_EN, aec held 0 -> rsp_valid with rsp_err=1 after 255 phi rises, ce never low.

Source files
------------

// File: rtl/vic_bus_master.sv
// Host-to-VIC register bus master: runs one CPU-style read or write per phi cycle.
// Optional WAIT timeout when compiled with BUS_MASTER_TIMEOUT_EN.
module vic_bus_master (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       clk_phi,
  input  logic       aec,
  input  logic       ba,
  input  logic       cmd_valid,
  input  logic       cmd_we,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_ready,
  output logic       ce,
  output logic       rw,
  output logic [5:0] ado,
  output logic [7:0] dbo,
  output logic       db_oe,
  input  logic [7:0] dbi,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;

  state_e     state_q, state_d;
  logic       phi_q;
  logic [4:0] phase_q, phase_d;
  logic       we_q, we_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rdy_q;
  logic       phi_rise;
  logic       start_ok;
  logic       in_window;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;
`endif

  assign phi_rise  = clk_phi & ~phi_q;
  // Reads must also wait for ba; writes only need the CPU to own the bus.
  assign start_ok  = phi_rise & aec & (we_q | ba);
  assign in_window = (state_q == S_ACCESS) && (phase_q >= 5'd1) && (phase_q <= 5'd15);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    phase_d   = phi_rise ? 5'd0 : ((phase_q == 5'd31) ? 5'd31 : phase_q + 5'd1);
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cmd_ready = rdy_q && (state_q == S_IDLE);
    ce        = 1'b1;
    rw        = 1'b1;
    ado       = 6'd0;
    dbo       = 8'd0;
    db_oe     = 1'b0;
    rsp_valid = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
    to_d      = to_q;
    err_d     = err_q;
`endif

    if (in_window) begin
      ce  = 1'b0;
      rw  = ~we_q;
      ado = addr_q;
      if (we_q && (phase_q >= 5'd2)) begin
        db_oe = 1'b1;
        dbo   = wdata_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = S_WAIT;
`ifdef BUS_MASTER_TIMEOUT_EN
          to_d    = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        if (start_ok) begin
          state_d = S_ACCESS;
`ifdef BUS_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (phi_rise) begin
          to_d = to_q + 8'd1;
          if (to_q == 8'd254) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_ACCESS: begin
        if (!we_q && (phase_q == 5'd14)) rdata_d = dbi;
        if (phase_q == 5'd16) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phi_q   <= 1'b0;
      phase_q <= 5'd31;
      we_q    <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      rdy_q   <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
      to_q    <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phi_q   <= clk_phi;
      phase_q <= phase_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= 1'b1;
`ifdef BUS_MASTER_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rsp_rdata = rdata_q;
`ifdef BUS_MASTER_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
